// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and synchronous flush.
// Optionally adds a 2-entry skid buffer. Also keeps a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t            state_p1;
  logic              vld_p1;
  logic              rdy_p1;
  logic [DATA_W-1:0] m_data_p1;
  logic [DATA_W-1:0] s_data_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              accept;
  logic              consume;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Without a skid entry, readiness must see this cycle's downstream consume.
  assign in_ready  = SKID ? rdy_p1 : (!vld_p1 || out_ready);
  assign out_valid = vld_p1;
  assign out_data  = m_data_p1;
  assign stall_cnt = cnt_p1;
  assign accept    = in_valid && in_ready;
  assign consume   = vld_p1 && out_ready;

  // Stage p1: state, registered handshake outputs, payload and stall counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_p1  <= EMPTY;
      vld_p1    <= 1'b0;
      rdy_p1    <= 1'b1;
      m_data_p1 <= RESET_VAL;
      s_data_p1 <= RESET_VAL;
      cnt_p1    <= '0;
    end else begin
      if (vld_p1 && !out_ready && !flush)
        cnt_p1 <= sat_inc(cnt_p1);
      if (flush) begin
        // Held payloads stay in M/S; only the live flags are dropped.
        state_p1 <= EMPTY;
        vld_p1   <= 1'b0;
        rdy_p1   <= 1'b1;
      end else begin
        case (state_p1)
          EMPTY: begin
            if (accept) begin
              m_data_p1 <= in_data;
              state_p1  <= BUSY;
              vld_p1    <= 1'b1;
              rdy_p1    <= 1'b1;
            end
          end
          BUSY: begin
            if (accept && consume) begin
              m_data_p1 <= in_data;
            end else if (accept) begin
              s_data_p1 <= in_data;
              state_p1  <= FULL;
              rdy_p1    <= 1'b0;
            end else if (consume) begin
              state_p1  <= EMPTY;
              vld_p1    <= 1'b0;
              rdy_p1    <= 1'b1;
            end
          end
          FULL: begin
            if (consume) begin
              m_data_p1 <= s_data_p1;
              state_p1  <= BUSY;
              rdy_p1    <= 1'b1;
            end
          end
          default: begin
            state_p1 <= EMPTY;
            vld_p1   <= 1'b0;
            rdy_p1   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one single-register instance
// share stimulus; directed table, hand sequences and a queue-based random run.
module tb_pipe_stage_reg;

  localparam int                DW = 16;
  localparam int                CW = 4;
  localparam logic [DW-1:0]     RV = 16'h5A5A;

  logic          clk = 1'b0;
  logic          clr, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [CW-1:0] sc1, sc0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .RESET_VAL(RV), .CNT_W(CW)) dut1 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .stall_cnt(sc1));

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .RESET_VAL(RV), .CNT_W(CW)) dut0 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .stall_cnt(sc0));

  typedef struct {
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          rdy;
    logic          eov;
    logic [DW-1:0] ed;
    logic          eir;
    logic [CW-1:0] est;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t v(logic fl, logic iv, logic [DW-1:0] d, logic rdy,
                             logic eov, logic [DW-1:0] ed, logic eir, logic [CW-1:0] est);
    vec_t r;
    r.fl = fl; r.iv = iv; r.d = d; r.rdy = rdy;
    r.eov = eov; r.ed = ed; r.eir = eir; r.est = est;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d, input logic rdy);
    flush = fl; in_valid = iv; in_data = d; out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    drive(1'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
    #2 clr = 1'b1;
    #1;
    chk({tag, " ov1"}, ov1, 0);
    chk({tag, " od1"}, od1, RV);
    chk({tag, " ir1"}, ir1, 1);
    chk({tag, " sc1"}, sc1, 0);
    chk({tag, " ov0"}, ov0, 0);
    chk({tag, " od0"}, od0, RV);
    chk({tag, " sc0"}, sc0, 0);
    tick();
    drive(0, 0, '0, 0);
    clr = 1'b0;
    tick();
  endtask

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] seq;

  initial begin
    clr = 1'b0;
    drive(0, 0, '0, 0);
    #3;
    reset_check("reset0");

    for (int i = 0; i < 8; i++)
      tbl[i] = v(0, 1, DW'(i + 1), 1, 1, DW'(i + 1), 1, 0);
    tbl[8]  = v(0, 0, 16'h0, 1, 0, 16'h8, 1, 0);
    tbl[9]  = v(0, 1, 16'hA, 0, 1, 16'hA, 1, 0);
    tbl[10] = v(0, 1, 16'hB, 0, 1, 16'hA, 0, 1);
    tbl[11] = v(0, 0, 16'h0, 0, 1, 16'hA, 0, 2);
    tbl[12] = v(0, 0, 16'h0, 1, 1, 16'hB, 1, 2);
    tbl[13] = v(0, 0, 16'h0, 1, 0, 16'hB, 1, 2);
    tbl[14] = v(0, 1, 16'hA, 0, 1, 16'hA, 1, 2);
    tbl[15] = v(0, 1, 16'hB, 0, 1, 16'hA, 0, 3);
    tbl[16] = v(1, 1, 16'hC, 0, 0, 16'hA, 1, 3);
    tbl[17] = v(0, 0, 16'h0, 1, 0, 16'hA, 1, 3);
    tbl[18] = v(0, 1, 16'hD, 1, 1, 16'hD, 1, 3);
    tbl[19] = v(0, 0, 16'h0, 1, 0, 16'hD, 1, 3);
    tbl[20] = v(0, 1, 16'hE, 0, 1, 16'hE, 1, 3);
    tbl[21] = v(1, 0, 16'h0, 1, 0, 16'hE, 1, 3);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].rdy);
      tick();
      chk($sformatf("row%0d out_valid", i), ov1, tbl[i].eov);
      chk($sformatf("row%0d out_data", i), od1, tbl[i].ed);
      chk($sformatf("row%0d in_ready", i), ir1, tbl[i].eir);
      chk($sformatf("row%0d stall_cnt", i), sc1, tbl[i].est);
    end

    reset_check("reset_mid");

    // Single-register instance: stall holds data, then replace with no bubble
    drive(0, 1, 16'h11, 0);
    #1 chk("s0 ready empty", ir0, 1);
    tick();
    chk("s0 load valid", ov0, 1);
    chk("s0 load data", od0, 16'h11);
    drive(0, 1, 16'h22, 0);
    #1 chk("s0 ready stalled", ir0, 0);
    tick();
    chk("s0 held data", od0, 16'h11);
    chk("s0 held valid", ov0, 1);
    chk("s0 stall", sc0, 1);
    drive(0, 1, 16'h22, 1);
    #1 chk("s0 ready passthru", ir0, 1);
    tick();
    chk("s0 replace data", od0, 16'h22);
    chk("s0 replace valid", ov0, 1);
    drive(0, 0, 16'h0, 1);
    tick();
    chk("s0 drain valid", ov0, 0);
    chk("s0 drain data", od0, 16'h22);

    // Saturation of the 4-bit stall counter
    reset_check("reset_sat");
    drive(0, 1, 16'h33, 0);
    tick();
    drive(0, 0, 16'h0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat10 sc1", sc1, 10);
    chk("sat10 sc0", sc0, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat20 sc1", sc1, 15);
    chk("sat20 sc0", sc0, 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat25 sc1", sc1, 15);
    chk("sat25 sc0", sc0, 15);
    chk("sat data1", od1, 16'h33);

    // Random valid/ready traffic checked against per-instance FIFO models
    reset_check("reset_rand");
    seq = 16'h0100;
    for (int c = 0; c < 10000; c++) begin
      drive(0, ($urandom_range(0, 3) != 0), seq, ($urandom_range(0, 2) != 0));
      seq = seq + 16'h1;
      if (c >= 9950) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("rand1 underflow", 1, 0);
        else chk("rand1 data", od1, q1.pop_front());
      end
      if (ov0 && out_ready) begin
        if (q0.size() == 0) chk("rand0 underflow", 1, 0);
        else chk("rand0 data", od0, q0.pop_front());
      end
      if (in_valid && ir1) q1.push_back(in_data);
      if (in_valid && ir0) q0.push_back(in_data);
      if (q1.size() > 2) chk("rand1 depth", q1.size(), 2);
      tick();
    end
    chk("rand1 drained", q1.size(), 0);
    chk("rand0 drained", q0.size(), 0);
    chk("rand1 idle", ov1, 0);
    chk("rand0 idle", ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
